// File: rtl/game_pkg.sv
// Shared types and default sizing for the Flappy Bird game blocks.
// The bird and pipe datapaths reuse these defaults so the whole game scales together.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_PLAY = 2'd2,
      ST_DEAD = 2'd3
   } game_state_e;

   localparam int TICK_DIV_DEF  = 8;
   localparam int SCORE_W_DEF   = 7;
   localparam int DEAD_HOLD_DEF = 4;

endpackage

// File: rtl/tick_divider.sv
// Game-tick divider: counts enabled cycles 0..DIV-1 and pulses on the terminal count.
// The count freezes while enable is low and returns to zero on clear.
module tick_divider
   import game_pkg::*;
#(
   parameter int DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic pulse
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign pulse = enable & (cnt_q == TERM);

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: owns game state, tick pacing, death merge, score and restart clear.
//   state | meaning
//   IDLE  | power-up / after reset, waiting for start
//   ARM   | one cycle, clearPlay pulse, score and tick counter cleared
//   PLAY  | game running, ticks issued, score counts pipes
//   DEAD  | bird died, score frozen, restart accepted after DEAD_HOLD cycles
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int SCORE_W   = SCORE_W_DEF,
   parameter int DEAD_HOLD = DEAD_HOLD_DEF
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               start,
   input  logic               edgeDeath,
   input  logic               pipeDeath,
   input  logic               pipePassed,
   output logic               tick,
   output logic               playing,
   output logic               dead,
   output logic               clearPlay,
   output logic [SCORE_W-1:0] score
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_ARM  = ST_ARM;
   localparam logic [1:0] S_PLAY = ST_PLAY;
   localparam logic [1:0] S_DEAD = ST_DEAD;

   localparam int HW = $clog2(DEAD_HOLD + 1);
   localparam logic [HW-1:0]      HOLD_DONE = HW'(DEAD_HOLD);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic [1:0]         state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [HW-1:0]      hold_q,  hold_d;

   logic death;
   logic in_play;
   logic tick_en;
   logic hold_ok;

   assign death   = edgeDeath | pipeDeath;
   assign in_play = (state_q == S_PLAY);
   assign tick_en = in_play & ~death;
   assign hold_ok = (hold_q == HOLD_DONE);

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_ARM;
         end
         S_ARM: begin
            state_d = S_PLAY;
            score_d = '0;
         end
         S_PLAY: begin
            // A death in the same cycle as a pipe pass must not award the point.
            if (death) begin
               state_d = S_DEAD;
               hold_d  = '0;
            end else if (pipePassed && (score_q != SCORE_MAX)) begin
               score_d = score_q + SCORE_W'(1);
            end
         end
         S_DEAD: begin
            if (!hold_ok) begin
               hold_d = hold_q + HW'(1);
            end else if (start) begin
               state_d = S_ARM;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         score_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         hold_q  <= hold_d;
      end
   end

   tick_divider #(
      .DIV (TICK_DIV)
   ) u_tick_divider (
      .clk    (Clock),
      .rst    (Reset),
      .clear  (state_q == S_ARM),
      .enable (tick_en),
      .pulse  (tick)
   );

   assign playing   = in_play;
   assign dead      = (state_q == S_DEAD);
   assign clearPlay = (state_q == S_ARM);
   assign score     = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with TICK_DIV=4, SCORE_W=3, DEAD_HOLD=3.
module tb_game_flow_ctrl;

   localparam int TD = 4;
   localparam int SW = 3;
   localparam int DH = 3;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          start = 1'b0;
   logic          edgeDeath = 1'b0;
   logic          pipeDeath = 1'b0;
   logic          pipePassed = 1'b0;
   logic          tick, playing, dead, clearPlay;
   logic [SW-1:0] score;

   int n_pass = 0;
   int n_total = 0;
   int cyc_no = 0;
   int play_start = 0;

   always #5 Clock = ~Clock;

   game_flow_ctrl #(
      .TICK_DIV  (TD),
      .SCORE_W   (SW),
      .DEAD_HOLD (DH)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .start      (start),
      .edgeDeath  (edgeDeath),
      .pipeDeath  (pipeDeath),
      .pipePassed (pipePassed),
      .tick       (tick),
      .playing    (playing),
      .dead       (dead),
      .clearPlay  (clearPlay),
      .score      (score)
   );

   task automatic next_cycle();
      @(posedge Clock);
      #1;
      cyc_no++;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      next_cycle();
      next_cycle();
      Reset = 1'b0;
      #1;
      n_total++; if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else n_pass++;
      n_total++; if (playing !== 1'b0) $display("FAIL reset_playing got=%b exp=0", playing); else n_pass++;
      n_total++; if (dead !== 1'b0) $display("FAIL reset_dead got=%b exp=0", dead); else n_pass++;
      n_total++; if (clearPlay !== 1'b0) $display("FAIL reset_clear got=%b exp=0", clearPlay); else n_pass++;
      n_total++; if (score !== 3'd0) $display("FAIL reset_score got=%0d exp=0", score); else n_pass++;
      next_cycle();
   endtask

   task automatic test_idle();
      for (int c = 0; c < 20; c++) begin
         #1;
         n_total++; if (tick !== 1'b0) $display("FAIL idle_tick c=%0d got=%b exp=0", c, tick); else n_pass++;
         n_total++; if (playing !== 1'b0) $display("FAIL idle_playing c=%0d got=%b exp=0", c, playing); else n_pass++;
         n_total++; if (dead !== 1'b0) $display("FAIL idle_dead c=%0d got=%b exp=0", c, dead); else n_pass++;
         n_total++; if (clearPlay !== 1'b0) $display("FAIL idle_clear c=%0d got=%b exp=0", c, clearPlay); else n_pass++;
         n_total++; if (score !== 3'd0) $display("FAIL idle_score c=%0d got=%0d exp=0", c, score); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_start_latency();
      logic exp_cp, exp_pl, exp_tk;
      for (int c = 0; c < 14; c++) begin
         start = (c == 0);
         #1;
         exp_cp = (c == 1);
         exp_pl = (c >= 2);
         exp_tk = (c == 5) || (c == 9) || (c == 13);
         n_total++; if (clearPlay !== exp_cp) $display("FAIL lat_clear c=%0d got=%b exp=%b", c, clearPlay, exp_cp); else n_pass++;
         n_total++; if (playing !== exp_pl) $display("FAIL lat_playing c=%0d got=%b exp=%b", c, playing, exp_pl); else n_pass++;
         n_total++; if (tick !== exp_tk) $display("FAIL lat_tick c=%0d got=%b exp=%b", c, tick, exp_tk); else n_pass++;
         if (c == 2) begin
            play_start = cyc_no;
            n_total++; if (score !== 3'd0) $display("FAIL lat_score got=%0d exp=0", score); else n_pass++;
         end
         next_cycle();
      end
      start = 1'b0;
   endtask

   // Score must start at 0; n pulses on consecutive cycles.
   task automatic test_score_count(input int n);
      logic exp_tk;
      for (int i = 0; i < n; i++) begin
         pipePassed = 1'b1;
         #1;
         exp_tk = (((cyc_no - play_start) % TD) == TD - 1);
         n_total++; if (score !== SW'(i)) $display("FAIL score_step i=%0d got=%0d exp=%0d", i, score, i); else n_pass++;
         n_total++; if (tick !== exp_tk) $display("FAIL score_tick i=%0d got=%b exp=%b", i, tick, exp_tk); else n_pass++;
         next_cycle();
      end
      pipePassed = 1'b0;
      #1;
      n_total++; if (score !== SW'(n)) $display("FAIL score_total got=%0d exp=%0d", score, n); else n_pass++;
   endtask

   task automatic test_saturation();
      int exp_s;
      for (int i = 0; i < 9; i++) begin
         pipePassed = 1'b1;
         #1;
         exp_s = (i < 7) ? i : 7;
         n_total++; if (score !== SW'(exp_s)) $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, score, exp_s); else n_pass++;
         next_cycle();
      end
      pipePassed = 1'b0;
      #1;
      n_total++; if (score !== 3'd7) $display("FAIL sat_final got=%0d exp=7", score); else n_pass++;
      next_cycle();
      n_total++; if (score !== 3'd7) $display("FAIL sat_hold got=%0d exp=7", score); else n_pass++;
   endtask

   task automatic test_death(input int exp_score);
      for (int k = 0; k < TD; k++) begin
         if (((cyc_no - play_start) % TD) != TD - 1) next_cycle();
      end
      edgeDeath  = 1'b1;
      pipePassed = 1'b1;
      #1;
      n_total++; if (tick !== 1'b0) $display("FAIL death_tick_mask got=%b exp=0", tick); else n_pass++;
      n_total++; if (playing !== 1'b1) $display("FAIL death_playing_same got=%b exp=1", playing); else n_pass++;
      next_cycle();
      pipePassed = 1'b0;
      #1;
      n_total++; if (dead !== 1'b1) $display("FAIL death_dead got=%b exp=1", dead); else n_pass++;
      n_total++; if (playing !== 1'b0) $display("FAIL death_playing got=%b exp=0", playing); else n_pass++;
      n_total++; if (score !== SW'(exp_score)) $display("FAIL death_score got=%0d exp=%0d", score, exp_score); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL death_tick got=%b exp=0", tick); else n_pass++;
   endtask

   // Entered in the first DEAD cycle with edgeDeath still high.
   task automatic test_dead_restart(input int old_score);
      pipeDeath = 1'b1;
      next_cycle();
      start = 1'b1;
      #1;
      n_total++; if (dead !== 1'b1) $display("FAIL hold_dead1 got=%b exp=1", dead); else n_pass++;
      next_cycle();
      start = 1'b0;
      #1;
      n_total++; if (dead !== 1'b1) $display("FAIL hold_ignored_dead got=%b exp=1", dead); else n_pass++;
      n_total++; if (clearPlay !== 1'b0) $display("FAIL hold_ignored_clear got=%b exp=0", clearPlay); else n_pass++;
      next_cycle();
      start = 1'b1;
      #1;
      n_total++; if (dead !== 1'b1) $display("FAIL hold_dead3 got=%b exp=1", dead); else n_pass++;
      next_cycle();
      start = 1'b0;
      #1;
      n_total++; if (clearPlay !== 1'b1) $display("FAIL restart_clear got=%b exp=1", clearPlay); else n_pass++;
      n_total++; if (dead !== 1'b0) $display("FAIL restart_dead got=%b exp=0", dead); else n_pass++;
      n_total++; if (playing !== 1'b0) $display("FAIL restart_playing_arm got=%b exp=0", playing); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL restart_tick_arm got=%b exp=0", tick); else n_pass++;
      n_total++; if (score !== SW'(old_score)) $display("FAIL restart_score_arm got=%0d exp=%0d", score, old_score); else n_pass++;
      next_cycle();
      edgeDeath = 1'b0;
      pipeDeath = 1'b0;
      #1;
      play_start = cyc_no;
      n_total++; if (playing !== 1'b1) $display("FAIL restart_playing got=%b exp=1", playing); else n_pass++;
      n_total++; if (clearPlay !== 1'b0) $display("FAIL restart_clear_end got=%b exp=0", clearPlay); else n_pass++;
      n_total++; if (score !== 3'd0) $display("FAIL restart_score got=%0d exp=0", score); else n_pass++;
   endtask

   task automatic test_reset_mid_play();
      Reset = 1'b1;
      #1;
      n_total++; if (playing !== 1'b1) $display("FAIL rst_mid_before got=%b exp=1", playing); else n_pass++;
      next_cycle();
      Reset = 1'b0;
      #1;
      n_total++; if (playing !== 1'b0) $display("FAIL rst_mid_playing got=%b exp=0", playing); else n_pass++;
      n_total++; if (dead !== 1'b0) $display("FAIL rst_mid_dead got=%b exp=0", dead); else n_pass++;
      n_total++; if (clearPlay !== 1'b0) $display("FAIL rst_mid_clear got=%b exp=0", clearPlay); else n_pass++;
      n_total++; if (tick !== 1'b0) $display("FAIL rst_mid_tick got=%b exp=0", tick); else n_pass++;
      n_total++; if (score !== 3'd0) $display("FAIL rst_mid_score got=%0d exp=0", score); else n_pass++;
      next_cycle();
      n_total++; if (playing !== 1'b0) $display("FAIL rst_mid_idle got=%b exp=0", playing); else n_pass++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_idle();
      test_start_latency();
      test_score_count(3);
      test_death(3);
      test_dead_restart(3);
      test_score_count(5);
      test_reset_mid_play();
      test_start_latency();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
